router_output_arbiter: RTL

- Downstream stage of the 3-channel packet router.
- Drains the router's three per-channel output FIFOs into one byte stream with a valid/ready handshake and a channel tag.
- Channels are served round-robin. Each grant is capped at a fixed burst length so that no channel starves the others.
- Drives the router's `read_enb` strobes directly; FIFO heads are first-word-fall-through.

---
 rtl/router_output_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: drains three first-word-fall-through FIFOs round-robin into one valid/ready byte stream.
// Each grant stops after BURST_MAX bytes or when its FIFO empties.
module router_output_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  vld_in,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  input  logic [7:0]  data_in_2,
  output logic [2:0]  read_enb,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic [1:0]  m_chan,
  input  logic        m_ready,
  output logic [15:0] tx_count
);
  typedef enum logic {ARB, SERVE} state_t;
  state_t state, state_nx;
  logic [1:0] cur, cur_nx, last, last_nx, p1, p2, grant, m_chan_nx;
  logic [3:0] burst_cnt, burst_nx, vld4;
  logic [7:0] din, m_data_nx;
  logic pop, m_valid_nx;
  assign vld4 = {1'b0, vld_in};
  assign p1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
  assign p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
  assign grant = vld4[p1] ? p1 : vld4[p2] ? p2 : last;
  assign din = (cur == 2'd0) ? data_in_0 : (cur == 2'd1) ? data_in_1 : data_in_2;
  // A pop needs a non-empty head and an output register that is empty or being drained this cycle.
  assign pop = (state == SERVE) && vld4[cur] && (!m_valid || m_ready);
  assign read_enb = {3{pop}} & {cur == 2'd2, cur == 2'd1, cur == 2'd0};
  always_comb begin
    state_nx = state;
    cur_nx = cur;
    last_nx = last;
    burst_nx = burst_cnt;
    m_valid_nx = pop | (m_valid & ~m_ready);
    m_data_nx = pop ? din : m_data;
    m_chan_nx = pop ? cur : m_chan;
    if (state == ARB) begin
      if (|vld_in) begin
        state_nx = SERVE;
        cur_nx = grant;
        burst_nx = 4'd0;
      end
    end else begin
      burst_nx = burst_cnt + 4'(pop);
      if (!vld4[cur] || (pop && burst_cnt == 4'(BURST_MAX - 1))) begin
        state_nx = ARB;
        last_nx = cur;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ARB;
      cur <= 2'd0;
      last <= 2'd2;
      burst_cnt <= 4'd0;
      m_valid <= 1'b0;
      m_data <= 8'h00;
      m_chan <= 2'd0;
      tx_count <= 16'd0;
    end else begin
      state <= state_nx;
      cur <= cur_nx;
      last <= last_nx;
      burst_cnt <= burst_nx;
      m_valid <= m_valid_nx;
      m_data <= m_data_nx;
      m_chan <= m_chan_nx;
      tx_count <= tx_count + 16'(m_valid && m_ready);
    end
  end
endmodule
